// File: rtl/debounce_event_ctrl.sv
// Multi-channel button debouncer with press / long-press / release events
// queued through a small first-word-fall-through FIFO.
module debounce_event_ctrl #(
    parameter int NUM_CH         = 4,
    parameter int TICK_DIV       = 250,
    parameter int DEBOUNCE_LIMIT = 20,
    parameter int LONG_LIMIT     = 100,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NUM_CH-1:0]         i_bouncy,
    output logic [NUM_CH-1:0]         o_debounced,
    output logic                      o_evt_valid,
    input  logic                      i_evt_ready,
    output logic [$clog2(NUM_CH)-1:0] o_evt_ch,
    output logic [1:0]                o_evt_type,
    output logic                      o_overflow,
    input  logic                      i_clr_overflow
);

    localparam int CW = $clog2(NUM_CH);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_LIMIT + 1);
    localparam int HW = $clog2(LONG_LIMIT + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = CW + 2;

    logic [NUM_CH-1:0] sync1_q, sync2_q;
    logic [NUM_CH-1:0] state_q, state_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic              tick;
    logic [DW-1:0]     cnt_q  [NUM_CH];
    logic [DW-1:0]     cnt_d  [NUM_CH];
    logic [HW-1:0]     hold_q [NUM_CH];
    logic [HW-1:0]     hold_d [NUM_CH];

    logic [NUM_CH-1:0] press_q, press_d, long_q, long_d, rel_q, rel_d;
    logic [NUM_CH-1:0] set_press, set_long, set_rel;
    logic [NUM_CH-1:0] clr_press, clr_long, clr_rel;
    logic              ovf_q, ovf_d, lost;

    logic [EW-1:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]     count_q, count_d;
    logic              push, pop;
    logic [CW-1:0]     push_ch;
    logic [1:0]        push_type;

    assign tick = (pre_q == PW'(TICK_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    // Debounce filter and hold timer; event requests are raised in the flip cycle
    always_comb begin
        state_d   = state_q;
        set_press = '0;
        set_long  = '0;
        set_rel   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            hold_d[i] = hold_q[i];
            if (tick) begin
                if (sync2_q[i] != state_q[i]) begin
                    if (cnt_q[i] == DW'(DEBOUNCE_LIMIT - 1)) begin
                        state_d[i]   = sync2_q[i];
                        cnt_d[i]     = '0;
                        set_press[i] = sync2_q[i];
                        set_rel[i]   = ~sync2_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + DW'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
            if (!state_q[i]) begin
                hold_d[i] = '0;
            end else if (tick && hold_q[i] != HW'(LONG_LIMIT - 1)) begin
                hold_d[i] = hold_q[i] + HW'(1);
                if (hold_q[i] + HW'(1) == HW'(LONG_LIMIT - 1)) begin
                    set_long[i] = 1'b1;
                end
            end
        end
    end

    // Fixed-priority serializer: lowest channel, then press, long, release
    always_comb begin
        push      = 1'b0;
        push_ch   = '0;
        push_type = 2'b00;
        clr_press = '0;
        clr_long  = '0;
        clr_rel   = '0;
        if (count_q != NW'(FIFO_DEPTH)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!push) begin
                    if (press_q[i]) begin
                        push         = 1'b1;
                        push_ch      = CW'(i);
                        push_type    = 2'b01;
                        clr_press[i] = 1'b1;
                    end else if (long_q[i]) begin
                        push        = 1'b1;
                        push_ch     = CW'(i);
                        push_type   = 2'b10;
                        clr_long[i] = 1'b1;
                    end else if (rel_q[i]) begin
                        push       = 1'b1;
                        push_ch    = CW'(i);
                        push_type  = 2'b00;
                        clr_rel[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        press_d = (press_q & ~clr_press) | set_press;
        long_d  = (long_q  & ~clr_long)  | set_long;
        rel_d   = (rel_q   & ~clr_rel)   | set_rel;
        lost    = |(set_press & press_q & ~clr_press)
                | |(set_long  & long_q  & ~clr_long)
                | |(set_rel   & rel_q   & ~clr_rel);
        // A new loss in the same cycle as a clear keeps the flag set
        ovf_d   = (ovf_q & ~i_clr_overflow) | lost;
    end

    assign pop      = o_evt_valid && i_evt_ready;
    assign wr_ptr_d = wr_ptr_q + AW'(push);
    assign rd_ptr_d = rd_ptr_q + AW'(pop);
    assign count_d  = count_q + NW'(push) - NW'(pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            state_q  <= '0;
            pre_q    <= '0;
            press_q  <= '0;
            long_q   <= '0;
            rel_q    <= '0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= '0;
                hold_q[i] <= '0;
            end
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            sync1_q  <= i_bouncy;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            pre_q    <= pre_d;
            press_q  <= press_d;
            long_q   <= long_d;
            rel_q    <= rel_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                hold_q[i] <= hold_d[i];
            end
            if (push) begin
                mem_q[wr_ptr_q] <= {push_ch, push_type};
            end
        end
    end

    assign o_debounced = state_q;
    assign o_evt_valid = (count_q != '0);
    assign o_evt_ch    = mem_q[rd_ptr_q][EW-1:2];
    assign o_evt_type  = mem_q[rd_ptr_q][1:0];
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_debounce_event_ctrl.sv
// Scoreboard bench for debounce_event_ctrl: a tick-level behavioural model
// predicts events and flags; the monitor compares every popped event.
module tb_debounce_event_ctrl;

    localparam int NCH = 2;
    localparam int TD  = 8;
    localparam int DL  = 3;
    localparam int LL  = 5;
    localparam int FD  = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [1:0] i_bouncy = 2'b00;
    logic [1:0] o_debounced;
    logic       o_evt_valid;
    logic       i_evt_ready = 1'b0;
    logic [0:0] o_evt_ch;
    logic [1:0] o_evt_type;
    logic       o_overflow;
    logic       i_clr_overflow = 1'b0;

    debounce_event_ctrl #(
        .NUM_CH(NCH), .TICK_DIV(TD), .DEBOUNCE_LIMIT(DL),
        .LONG_LIMIT(LL), .FIFO_DEPTH(FD)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_bouncy(i_bouncy),
        .o_debounced(o_debounced),
        .o_evt_valid(o_evt_valid),
        .i_evt_ready(i_evt_ready),
        .o_evt_ch(o_evt_ch),
        .o_evt_type(o_evt_type),
        .o_overflow(o_overflow),
        .i_clr_overflow(i_clr_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Bench-side phase counter: an edge where ph==7 is a sample tick edge
    logic [2:0] ph;
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ph <= 3'd0;
        else          ph <= ph + 3'd1;
    end

    int n_chk = 0;
    int n_err = 0;
    int n_pop = 0;

    logic [1:0] ms;
    int         mc [NCH];
    int         mh [NCH];
    bit   [1:0] mp, ml, mr;
    bit         movf;
    int         mcount;
    logic [2:0] exp_q [$];
    logic [2:0] e;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        ms = 2'b00;
        mp = '0;
        ml = '0;
        mr = '0;
        movf = 1'b0;
        mcount = 0;
        exp_q.delete();
        for (int c = 0; c < NCH; c++) begin
            mc[c] = 0;
            mh[c] = 0;
        end
    endfunction

    // Move pending model events into the model FIFO in priority order
    function automatic void drain();
        bit found;
        logic [2:0] ev;
        while (mcount < FD) begin
            found = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if (!found) begin
                    ev[2] = (c == 1);
                    if (mp[c]) begin
                        ev[1:0] = 2'b01; mp[c] = 1'b0; found = 1'b1;
                    end else if (ml[c]) begin
                        ev[1:0] = 2'b10; ml[c] = 1'b0; found = 1'b1;
                    end else if (mr[c]) begin
                        ev[1:0] = 2'b00; mr[c] = 1'b0; found = 1'b1;
                    end
                end
            end
            if (!found) break;
            exp_q.push_back(ev);
            mcount++;
        end
    endfunction

    function automatic void model_tick(input logic [1:0] v);
        for (int c = 0; c < NCH; c++) begin
            logic old;
            bit ep, el, er;
            old = ms[c];
            ep = 1'b0; el = 1'b0; er = 1'b0;
            if (v[c] != old) begin
                if (mc[c] == DL - 1) begin
                    ms[c] = v[c];
                    mc[c] = 0;
                    if (v[c]) ep = 1'b1;
                    else      er = 1'b1;
                end else begin
                    mc[c]++;
                end
            end else begin
                mc[c] = 0;
            end
            if (old) begin
                if (mh[c] < LL - 1) begin
                    mh[c]++;
                    if (mh[c] == LL - 1) el = 1'b1;
                end
            end else begin
                mh[c] = 0;
            end
            if (ep) begin if (mp[c]) movf = 1'b1; mp[c] = 1'b1; end
            if (el) begin if (ml[c]) movf = 1'b1; ml[c] = 1'b1; end
            if (er) begin if (mr[c]) movf = 1'b1; mr[c] = 1'b1; end
        end
        drain();
    endfunction

    task automatic step(input logic [1:0] v);
        i_bouncy = v;
        do @(posedge i_clk); while (ph != 3'd7);
        #1;
        model_tick(v);
        chk("debounced", o_debounced, ms);
        chk("overflow", o_overflow, movf);
    endtask

    task automatic steps(input logic [1:0] v, input int n);
        for (int k = 0; k < n; k++) step(v);
    endtask

    always @(negedge i_clk) begin
        if (i_rst_n && o_evt_valid && i_evt_ready) begin
            chk("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("evt_ch", o_evt_ch, e[2]);
                chk("evt_type", o_evt_type, e[1:0]);
                mcount--;
                drain();
            end
            n_pop++;
        end
    end

    int base;

    initial begin
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_deb", o_debounced, 0);
        chk("rst_valid", o_evt_valid, 0);
        chk("rst_ovf", o_overflow, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_evt_ready = 1'b1;

        // single press: latency from flip to head valid
        base = n_pop;
        steps(2'b01, 3);
        chk("lat_n0", o_evt_valid, 0);
        @(posedge i_clk);
        #1;
        chk("lat_n2", o_evt_valid, 1);
        chk("lat_ch", o_evt_ch, 0);
        chk("lat_type", o_evt_type, 2'b01);
        steps(2'b00, 3);
        repeat (4) @(posedge i_clk);
        chk("t1_pops", n_pop - base, 2);

        // bouncing input: only three consecutive highs count
        base = n_pop;
        step(2'b01); step(2'b01); step(2'b00);
        step(2'b01); step(2'b01);
        chk("bounce_hold", o_debounced, 2'b00);
        step(2'b01);
        steps(2'b00, 3);
        repeat (4) @(posedge i_clk);
        chk("t2_pops", n_pop - base, 2);

        // long press then release: press, long, release
        base = n_pop;
        steps(2'b01, 8);
        steps(2'b00, 3);
        repeat (4) @(posedge i_clk);
        chk("t3_pops", n_pop - base, 3);

        // both channels flip on the same tick
        base = n_pop;
        steps(2'b11, 3);
        steps(2'b00, 3);
        repeat (4) @(posedge i_clk);
        chk("t4_pops", n_pop - base, 4);

        // consumer stalled: FIFO fills, pending events collide
        base = n_pop;
        i_evt_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            steps(2'b01, 3);
            steps(2'b00, 3);
        end
        chk("full_valid", o_evt_valid, 1);
        chk("ovf_set", o_overflow, 1);
        i_clr_overflow = 1'b1;
        @(posedge i_clk);
        #1;
        i_clr_overflow = 1'b0;
        movf = 1'b0;
        chk("ovf_clr", o_overflow, 0);
        i_evt_ready = 1'b1;
        repeat (12) @(posedge i_clk);
        chk("t5_pops", n_pop - base, 6);
        chk("t5_empty", o_evt_valid, 0);

        // reset with queued events and a half-filtered release
        i_evt_ready = 1'b0;
        steps(2'b10, 3);
        steps(2'b11, 3);
        steps(2'b10, 2);
        chk("pre_rst_valid", o_evt_valid, 1);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        i_bouncy = 2'b11;
        #1;
        chk("arst_valid", o_evt_valid, 0);
        chk("arst_deb", o_debounced, 0);
        chk("arst_ovf", o_overflow, 0);
        model_reset();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_evt_ready = 1'b1;
        base = n_pop;
        steps(2'b11, 2);
        repeat (3) @(posedge i_clk);
        chk("no_stale", n_pop - base, 0);
        step(2'b11);
        steps(2'b00, 3);
        repeat (4) @(posedge i_clk);
        chk("t6_pops", n_pop - base, 4);

        repeat (10) @(posedge i_clk);
        chk("sb_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
